// File: rtl/plane_hypothesis_sequencer_pkg.sv
// Shared types and helpers for the RANSAC plane-hypothesis sequencer.
package plane_hypothesis_sequencer_pkg;

  localparam int          DEF_IDX_W     = 10;
  localparam int          DEF_HYP_W     = 16;
  localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } point_t;

  typedef struct packed {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [15:0] c;
    logic signed [15:0] d;
  } plane_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_READ  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr32_next(input logic [31:0] state, input logic [31:0] poly);
    return {1'b0, state[31:1]} ^ (state[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/plane_hypothesis_sequencer_index_lfsr.sv
// 32-bit Galois LFSR supplying candidate point indices; a zero seed is forced to 1
// because the all-zero state is a lock-up state.
module index_lfsr
  import plane_hypothesis_sequencer_pkg::*;
#(
  parameter int          IDX_W = DEF_IDX_W,
  parameter logic [31:0] POLY  = DEF_LFSR_POLY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      seed,
  output logic [IDX_W-1:0] cand
);

  logic [31:0] state_q;
  logic [31:0] state_d;
  logic [31:0] stepped;

  // Load has priority over step; the candidate is the low bits of the post-step value.
  always_comb begin
    stepped = lfsr32_next(state_q, POLY);
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      state_d = stepped;
    end
    cand = stepped[IDX_W-1:0];
  end

  // LFSR state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= 32'h1;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/plane_hypothesis_sequencer.sv
// Draws distinct random point triples, fetches them, runs find_plane on each and
// hands the resulting planes downstream tagged with their hypothesis number.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------------
//  IDLE     | waiting for start; degenerate runs finish here with a done pulse
//  DRAW     | stepping the LFSR until three distinct in-range indices are held
//  READ     | three buffer reads, data latched one cycle behind each strobe
//  ISSUE    | fp_input_valid high until find_plane accepts the triple
//  WAIT     | waiting for a fresh fp_output_valid (low seen, then high)
//  OUT      | plane_valid high until the downstream accepts the plane
module plane_hypothesis_sequencer
  import plane_hypothesis_sequencer_pkg::*;
#(
  parameter int          IDX_W     = DEF_IDX_W,
  parameter int          HYP_W     = DEF_HYP_W,
  parameter logic [31:0] LFSR_POLY = DEF_LFSR_POLY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W:0]   num_points,
  input  logic [HYP_W-1:0] num_hypotheses,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_addr,
  input  point_t           mem_rd_data,
  output point_t           fp_a,
  output point_t           fp_b,
  output point_t           fp_c,
  output logic             fp_input_valid,
  input  logic             fp_input_ready,
  input  logic             fp_output_valid,
  input  plane_t           fp_p,
  output logic             plane_valid,
  input  logic             plane_ready,
  output plane_t           plane,
  output logic [HYP_W-1:0] plane_index
);

  localparam logic [HYP_W-1:0] HYP_ONE   = HYP_W'(1);
  localparam logic [IDX_W:0]   MIN_POINTS = (IDX_W + 1)'(3);

  state_t           state_q, state_d;
  logic [IDX_W:0]   np_q, np_d;
  logic [HYP_W-1:0] nh_q, nh_d;
  logic [HYP_W-1:0] hyp_cnt_q, hyp_cnt_d;
  logic [1:0]       sel_cnt_q, sel_cnt_d;
  logic [IDX_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
  logic [1:0]       rd_cnt_q, rd_cnt_d;
  point_t           fp_a_q, fp_a_d, fp_b_q, fp_b_d, fp_c_q, fp_c_d;
  logic             seen_low_q, seen_low_d;
  plane_t           plane_q, plane_d;
  logic [HYP_W-1:0] plane_index_q, plane_index_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [IDX_W-1:0] cand;
  logic             start_go;
  logic             pts_short;
  logic             cand_ok;
  logic             capture;
  logic             last_hyp;

  index_lfsr #(
    .IDX_W (IDX_W),
    .POLY  (LFSR_POLY)
  ) u_index_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (start_go),
    .step  (state_q == ST_DRAW),
    .seed  (seed),
    .cand  (cand)
  );

  // Decision terms shared by the next-state and datapath logic.
  always_comb begin
    start_go  = (state_q == ST_IDLE) && start;
    pts_short = num_points < MIN_POINTS;
    cand_ok   = ({1'b0, cand} < np_q)
             && !((sel_cnt_q != 2'd0) && (cand == idx0_q))
             && !((sel_cnt_q == 2'd2) && (cand == idx1_q));
    // The first 1 only counts once a 0 has been seen, so a stale level from the
    // previous hypothesis can never be captured as this one's result.
    capture   = (state_q == ST_WAIT) && seen_low_q && fp_output_valid;
    last_hyp  = (hyp_cnt_q + HYP_ONE) == nh_q;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !pts_short && (num_hypotheses != '0)) state_d = ST_DRAW;
      end
      ST_DRAW:  if (cand_ok && (sel_cnt_q == 2'd2)) state_d = ST_READ;
      ST_READ:  if (rd_cnt_q == 2'd3) state_d = ST_ISSUE;
      ST_ISSUE: if (fp_input_ready) state_d = ST_WAIT;
      ST_WAIT:  if (capture) state_d = ST_OUT;
      ST_OUT: begin
        if (plane_ready) state_d = last_hyp ? ST_IDLE : ST_DRAW;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: run parameters, triple, fetched points, captured plane.
  always_comb begin
    np_d          = np_q;
    nh_d          = nh_q;
    hyp_cnt_d     = hyp_cnt_q;
    sel_cnt_d     = sel_cnt_q;
    idx0_d        = idx0_q;
    idx1_d        = idx1_q;
    idx2_d        = idx2_q;
    rd_cnt_d      = rd_cnt_q;
    fp_a_d        = fp_a_q;
    fp_b_d        = fp_b_q;
    fp_c_d        = fp_c_q;
    seen_low_d    = seen_low_q;
    plane_d       = plane_q;
    plane_index_d = plane_index_q;
    done_d        = 1'b0;
    error_d       = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          np_d      = num_points;
          nh_d      = num_hypotheses;
          hyp_cnt_d = '0;
          sel_cnt_d = 2'd0;
          rd_cnt_d  = 2'd0;
          error_d   = pts_short;
          done_d    = pts_short || (num_hypotheses == '0);
        end
      end
      ST_DRAW: begin
        if (cand_ok) begin
          case (sel_cnt_q)
            2'd0:    idx0_d = cand;
            2'd1:    idx1_d = cand;
            default: idx2_d = cand;
          endcase
          sel_cnt_d = (sel_cnt_q == 2'd2) ? 2'd0 : sel_cnt_q + 2'd1;
        end
      end
      ST_READ: begin
        // Counter wraps 3 -> 0, leaving it ready for the next hypothesis.
        rd_cnt_d = rd_cnt_q + 2'd1;
        case (rd_cnt_q)
          2'd1:    fp_a_d = mem_rd_data;
          2'd2:    fp_b_d = mem_rd_data;
          2'd3:    fp_c_d = mem_rd_data;
          default: ;
        endcase
      end
      ST_ISSUE: begin
        if (fp_input_ready) seen_low_d = 1'b0;
      end
      ST_WAIT: begin
        if (!fp_output_valid) seen_low_d = 1'b1;
        if (capture) begin
          plane_d       = fp_p;
          plane_index_d = hyp_cnt_q;
        end
      end
      ST_OUT: begin
        if (plane_ready) begin
          hyp_cnt_d = hyp_cnt_q + HYP_ONE;
          done_d    = last_hyp;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      np_q          <= '0;
      nh_q          <= '0;
      hyp_cnt_q     <= '0;
      sel_cnt_q     <= 2'd0;
      idx0_q        <= '0;
      idx1_q        <= '0;
      idx2_q        <= '0;
      rd_cnt_q      <= 2'd0;
      fp_a_q        <= '0;
      fp_b_q        <= '0;
      fp_c_q        <= '0;
      seen_low_q    <= 1'b0;
      plane_q       <= '0;
      plane_index_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      np_q          <= np_d;
      nh_q          <= nh_d;
      hyp_cnt_q     <= hyp_cnt_d;
      sel_cnt_q     <= sel_cnt_d;
      idx0_q        <= idx0_d;
      idx1_q        <= idx1_d;
      idx2_q        <= idx2_d;
      rd_cnt_q      <= rd_cnt_d;
      fp_a_q        <= fp_a_d;
      fp_b_q        <= fp_b_d;
      fp_c_q        <= fp_c_d;
      seen_low_q    <= seen_low_d;
      plane_q       <= plane_d;
      plane_index_q <= plane_index_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Output decode from state and registered datapath.
  always_comb begin
    busy           = (state_q != ST_IDLE);
    mem_rd_en      = (state_q == ST_READ) && (rd_cnt_q != 2'd3);
    mem_addr       = '0;
    if (state_q == ST_READ) begin
      case (rd_cnt_q)
        2'd0:    mem_addr = idx0_q;
        2'd1:    mem_addr = idx1_q;
        2'd2:    mem_addr = idx2_q;
        default: mem_addr = '0;
      endcase
    end
    fp_input_valid = (state_q == ST_ISSUE);
    plane_valid    = (state_q == ST_OUT);
    done           = done_q;
    error          = error_q;
    fp_a           = fp_a_q;
    fp_b           = fp_b_q;
    fp_c           = fp_c_q;
    plane          = plane_q;
    plane_index    = plane_index_q;
  end

endmodule

// File: tb/tb_plane_hypothesis_sequencer.sv
// Bench for plane_hypothesis_sequencer: 1-cycle point buffer, 20-cycle find_plane stub,
// reference model that replays the LFSR draw rule to predict triples and planes.
module tb_plane_hypothesis_sequencer;
  import plane_hypothesis_sequencer_pkg::*;

  localparam int IW = DEF_IDX_W;
  localparam int HW = DEF_HYP_W;
  localparam logic [31:0] POLY = DEF_LFSR_POLY;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   num_points = '0;
  logic [HW-1:0] num_hypotheses = '0;
  logic [31:0]   seed_i = '0;
  logic          busy, done, error, mem_rd_en;
  logic [IW-1:0] mem_addr;
  point_t        mem_rd_data = '0;
  point_t        fp_a, fp_b, fp_c;
  logic          fp_input_valid;
  logic          fp_input_ready;
  logic          fp_output_valid = 1'b0;
  plane_t        fp_p = '0;
  logic          plane_valid;
  logic          plane_ready = 1'b0;
  plane_t        plane;
  logic [HW-1:0] plane_index;

  int checks = 0;
  int failures = 0;

  plane_hypothesis_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .num_points(num_points),
    .num_hypotheses(num_hypotheses), .seed(seed_i), .busy(busy), .done(done),
    .error(error), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .fp_a(fp_a), .fp_b(fp_b), .fp_c(fp_c), .fp_input_valid(fp_input_valid),
    .fp_input_ready(fp_input_ready), .fp_output_valid(fp_output_valid), .fp_p(fp_p),
    .plane_valid(plane_valid), .plane_ready(plane_ready), .plane(plane),
    .plane_index(plane_index)
  );

  always #5 clock = ~clock;

  function automatic plane_t plane_fn(input point_t a, input point_t b, input point_t c);
    plane_t p;
    p.a = a.x + b.y;
    p.b = b.z ^ c.x;
    p.c = c.y - a.z;
    p.d = a.x ^ b.x ^ c.x ^ 16'sh5A5A;
    return p;
  endfunction

  // Point buffer: one-cycle read latency.
  point_t mem [0:1023];
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // find_plane stub: accepts after ready_delay cycles of valid, answers 20 cycles later,
  // output_valid is a level that drops only when the next triple is accepted.
  int ready_delay = 0;
  int stall_cnt;
  int lat_cnt;
  point_t sa, sb, sc;
  assign fp_input_ready = (stall_cnt >= ready_delay);
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fp_output_valid <= 1'b0;
      fp_p            <= '0;
      stall_cnt       <= 0;
      lat_cnt         <= 0;
    end else if (fp_input_valid && fp_input_ready) begin
      fp_output_valid <= 1'b0;
      stall_cnt       <= 0;
      lat_cnt         <= 20;
      sa <= fp_a; sb <= fp_b; sc <= fp_c;
    end else begin
      if (fp_input_valid) stall_cnt <= stall_cnt + 1;
      if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          fp_output_valid <= 1'b1;
          fp_p            <= plane_fn(sa, sb, sc);
        end
      end
    end
  end

  // Activity monitors.
  int hs_cnt = 0, vcnt = 0, rdcnt = 0, unstable = 0, rd_wr = 0;
  logic [IW-1:0] rd_log [0:4095];
  logic prev_v = 1'b0, prev_hs = 1'b0;
  logic [143:0] prev_abc = '0;
  always @(posedge clock) begin
    if (mem_rd_en) begin
      rd_log[rd_wr % 4096] = mem_addr;
      rd_wr = rd_wr + 1;
      rdcnt = rdcnt + 1;
    end
    if (fp_input_valid) vcnt = vcnt + 1;
    if (fp_input_valid && prev_v && !prev_hs && ({fp_a, fp_b, fp_c} !== prev_abc))
      unstable = unstable + 1;
    if (fp_input_valid && fp_input_ready) hs_cnt = hs_cnt + 1;
    prev_v   = fp_input_valid;
    prev_hs  = fp_input_valid && fp_input_ready;
    prev_abc = {fp_a, fp_b, fp_c};
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference draw: replay the LFSR, keep in-range values not already in the triple.
  task automatic model_triple(inout logic [31:0] s, input int np,
                              output int t0, output int t1, output int t2);
    int t[3];
    int n;
    int c;
    n = 0;
    while (n < 3) begin
      s = (s >> 1) ^ ((s & 32'h1) != 0 ? POLY : 32'h0);
      c = int'(s % 1024);
      if (c < np && !(n > 0 && c == t[0]) && !(n > 1 && c == t[1])) begin
        t[n] = c;
        n++;
      end
    end
    t0 = t[0]; t1 = t[1]; t2 = t[2];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {58'h0, busy, done, error, mem_rd_en, fp_input_valid, plane_valid}, 64'h0);
    check({tag, "_addr"}, 64'(mem_addr), 64'h0);
    check({tag, "_fp"}, 64'(fp_a | fp_b | fp_c), 64'h0);
    check({tag, "_plane"}, plane, 64'h0);
    check({tag, "_pidx"}, 64'(plane_index), 64'h0);
  endtask

  task automatic run(input int np, input int nh, input logic [31:0] sd, input int hold_hyp,
                     input int abort_hyp, input bit rand_rdy);
    logic [31:0] m;
    int t0, t1, t2, rp, base_hs, bad;
    plane_t snap_p;
    logic [HW-1:0] snap_i;
    num_points = (IW + 1)'(np);
    num_hypotheses = HW'(nh);
    seed_i = sd;
    start = 1'b1;
    cycle();
    start = 1'b0;
    m = (sd == 0) ? 32'h1 : sd;
    rp = rd_wr;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    if (rand_rdy) begin
      num_points = 1;
      num_hypotheses = 1;
    end
    for (int h = 0; h < nh; h++) begin
      model_triple(m, np, t0, t1, t2);
      base_hs = hs_cnt;
      if (h == abort_hyp) begin
        for (int k = 0; k < 30000 && hs_cnt == base_hs; k++) cycle();
        check("abort_issue_seen", 64'(hs_cnt), 64'(base_hs + 1));
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) cycle();
        check_reset_outputs("abort_hold");
        reset = 1'b1;
        cycle();
        return;
      end
      for (int k = 0; k < 30000 && !plane_valid; k++) begin
        if (rand_rdy) start = 1'($urandom_range(0, 1));
        cycle();
      end
      start = 1'b0;
      check("plane_valid_seen", plane_valid, 1);
      if (!plane_valid) return;
      check("busy_in_out", busy, 1);
      check("reads_per_hyp", 64'(rd_wr - rp), 64'd3);
      check("triple_idx0", 64'(rd_log[rp % 4096]), 64'(t0));
      check("triple_idx1", 64'(rd_log[(rp + 1) % 4096]), 64'(t1));
      check("triple_idx2", 64'(rd_log[(rp + 2) % 4096]), 64'(t2));
      rp += 3;
      check("plane_index", 64'(plane_index), 64'(h));
      check("plane_value", plane, plane_fn(mem[t0], mem[t1], mem[t2]));
      if (h == hold_hyp) begin
        snap_p = plane;
        snap_i = plane_index;
        bad = 0;
        repeat (100) begin
          cycle();
          if (!plane_valid || plane !== snap_p || plane_index !== snap_i) bad++;
        end
        check("hold_stable", 64'(bad), 64'h0);
        check("hold_no_issue", 64'(hs_cnt), 64'(base_hs + 1));
      end
      if (rand_rdy) repeat ($urandom_range(0, 3)) cycle();
      plane_ready = 1'b1;
      cycle();
      plane_ready = 1'b0;
      check("done_at_end", done, (h == nh - 1) ? 1'b1 : 1'b0);
      check("busy_after_hs", busy, (h == nh - 1) ? 1'b0 : 1'b1);
    end
    cycle();
    check("done_one_cycle", done, 0);
  endtask

  int rd0, v0, h0, u0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = point_t'({$urandom, $urandom});
    reset = 1'b0;
    repeat (3) cycle();
    check_reset_outputs("reset");
    reset = 1'b1;
    cycle();

    // minimal buffer: triple is a permutation of {0,1,2}
    run(3, 1, 32'h1, -1, -1, 1'b0);

    // long run from a fixed seed
    run(1000, 50, 32'hACE1, -1, -1, 1'b0);

    // too few points: done+error, no activity
    rd0 = rdcnt; v0 = vcnt;
    num_points = 2; num_hypotheses = 5; seed_i = $urandom;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("short_done", done, 1);
    check("short_error", error, 1);
    check("short_busy", busy, 0);
    cycle();
    check("short_done_pulse", done, 0);
    repeat (5) cycle();
    check("short_error_held", error, 1);
    check("short_no_reads", 64'(rdcnt), 64'(rd0));
    check("short_no_issue", 64'(vcnt), 64'(v0));
    run(500, 1, $urandom, -1, -1, 1'b0);

    // zero hypotheses: immediate done, no error
    num_points = 10; num_hypotheses = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("zero_hyp_done", done, 1);
    check("zero_hyp_error", error, 0);
    cycle();

    // downstream backpressure
    run(800, 3, $urandom, 1, -1, 1'b0);

    // slow find_plane acceptance
    ready_delay = 7;
    v0 = vcnt; h0 = hs_cnt; u0 = unstable;
    run(1000, 2, $urandom, -1, -1, 1'b0);
    check("slow_valid_cycles", 64'(vcnt - v0), 64'd16);
    check("slow_handshakes", 64'(hs_cnt - h0), 64'd2);
    check("slow_stable", 64'(unstable - u0), 64'd0);
    ready_delay = 0;

    // reset during WAIT of hypothesis 3, then reproduce from the same seed
    run(1000, 6, 32'h1234_5678, -1, 3, 1'b0);
    run(1000, 6, 32'h1234_5678, -1, -1, 1'b0);

    // randomized runs with start/parameter noise while busy
    repeat (2) begin
      run($urandom_range(100, 1023), $urandom_range(2, 5), $urandom, -1, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
